// File: rtl/adc_capture.sv
//==============================================================================
// Module   : adc_capture
// Brief    : Paced capture front-end for a 12-bit AD7476-style serial ADC.
//            A free-running tick timer starts one CS_n-framed read per tick
//            while enabled and not held. SCLK idles high, leading zeros are
//            dropped, and the sample goes out on out_w with an rdy_w pulse.
//            Optional macro ADC_DROPCNT_EN adds a saturating count of
//            enabled ticks that could not start a frame (drop_cnt_w).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module adc_capture #(
    parameter int ADC_DATLEN    = 12,
    parameter int LEAD_ZEROS    = 4,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int RDY_WIDTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  hold,
    input  logic                  adc_sdata,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    output logic [0:ADC_DATLEN-1] out_w,
    output logic                  rdy_w
`ifdef ADC_DROPCNT_EN
    ,
    output logic [0:7]            drop_cnt_w
`endif
);

    // Frame geometry and counter widths
    localparam int c_NBITS  = LEAD_ZEROS + ADC_DATLEN;
    localparam int c_TMR_W  = $clog2(SAMPLE_PERIOD);
    localparam int c_DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int c_BIT_W  = $clog2(c_NBITS) + 1;
    localparam int c_RCNT_W = $clog2(RDY_WIDTH + 1) + 1;

    localparam logic [c_TMR_W-1:0]  c_TMR_LAST = c_TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(c_NBITS - 1);
    localparam logic [c_RCNT_W-1:0] c_RDY_LEN  = c_RCNT_W'(RDY_WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_LATCH  = 3'd3;
    localparam logic [2:0] S_STROBE = 3'd4;

    logic [c_TMR_W-1:0]    r_tmr;
    logic [2:0]            r_state;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_BIT_W-1:0]    r_bitcnt;
    logic [c_RCNT_W-1:0]   r_rcnt;
    logic [0:ADC_DATLEN-1] r_sr;
    logic [0:ADC_DATLEN-1] r_out;
    logic                  r_cs_n;
    logic                  r_sclk;
    logic                  r_rdy;

    logic w_tick;
    logic w_start;

    assign w_tick  = (r_tmr == c_TMR_LAST);
    // en and hold only matter in IDLE; a tick that misses this is lost
    assign w_start = w_tick & en & ~hold & (r_state == S_IDLE);

    assign adc_cs_n = r_cs_n;
    assign adc_sclk = r_sclk;
    assign out_w    = r_out;
    assign rdy_w    = r_rdy;

    // Free-running sample tick timer, independent of enable and state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tmr <= '0;
        end else if (w_tick) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    // Frame sequencer: CS_n framing, SCLK generation, sampling and strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b1;
            r_rdy    <= 1'b0;
            r_out    <= '0;
            r_sr     <= '0;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_rcnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_SETUP;
                        r_cs_n  <= 1'b0;
                        r_div   <= '0;
                        r_sr    <= '0;
                    end
                end
                S_SETUP: begin
                    // SCLK held high for CLK_DIV cycles after CS_n falls
                    if (r_div == c_DIV_LAST) begin
                        r_div    <= '0;
                        r_bitcnt <= '0;
                        r_sclk   <= 1'b0;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            // Rising SCLK edge: capture one bit. The register
                            // is only ADC_DATLEN wide, so the leading bits
                            // fall off the top whatever their value.
                            r_sclk <= 1'b1;
                            r_sr   <= {r_sr[1:ADC_DATLEN-1], adc_sdata};
                            if (r_bitcnt == c_BIT_LAST) begin
                                r_state <= S_LATCH;
                            end else begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end
                        end else begin
                            r_sclk <= 1'b0;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_LATCH: begin
                    r_cs_n  <= 1'b1;
                    r_out   <= r_sr;
                    r_rcnt  <= '0;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    // out_w already stable for a cycle before rdy_w rises
                    if (r_rcnt == c_RDY_LEN) begin
                        r_rdy   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rdy  <= 1'b1;
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADC_DROPCNT_EN
    logic [7:0] r_drop_cnt;
    logic       w_drop;

    assign w_drop     = w_tick & en & (hold | (r_state != S_IDLE));
    assign drop_cnt_w = r_drop_cnt;

    // Saturating count of enabled ticks that could not start a frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_capture.sv
//==============================================================================
// Module   : tb_adc_capture
// Brief    : Directed self-checking bench for adc_capture with a behavioural
//            AD7476-style ADC model and a frame timing monitor.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adc_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        hold;
    logic        adc_sdata;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [0:11] out_w;
    logic        rdy_w;
`ifdef ADC_DROPCNT_EN
    logic [0:7]  drop_cnt_w;
`endif

    adc_capture u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hold      (hold),
        .adc_sdata (adc_sdata),
        .adc_cs_n  (adc_cs_n),
        .adc_sclk  (adc_sclk),
        .out_w     (out_w),
        .rdy_w     (rdy_w)
`ifdef ADC_DROPCNT_EN
        ,
        .drop_cnt_w(drop_cnt_w)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle counter
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: 4 leading ones then the queued 12-bit value, MSB first,
    // each bit presented on an SCLK falling edge.
    logic [11:0] adc_q[$];
    logic [15:0] cur_word = 16'hFFFF;
    int          adc_idx  = 0;

    initial adc_sdata = 1'b1;

    always @(negedge adc_cs_n) begin
        if (adc_q.size() > 0) cur_word = {4'hF, adc_q.pop_front()};
        else                  cur_word = 16'hFFFF;
        adc_idx = 0;
    end

    always @(negedge adc_sclk) begin
        if (adc_cs_n === 1'b0 && adc_idx < 16) begin
            adc_sdata = cur_word[15 - adc_idx];
            adc_idx++;
        end
    end

    // Frame monitor, sampled on the inactive clock edge
    int          falls[$];
    logic [11:0] got[$];
    int          rises     = 0;
    int          bad_sclk  = 0;
    int          out_cyc   = -1;
    int          rdy_start = -1;
    int          rdy_end   = -1;
    int          rdy_cnt   = 0;
    logic        p_cs   = 1'b1;
    logic        p_sclk = 1'b1;
    logic        p_rdy  = 1'b0;
    logic [11:0] p_out  = 12'h0;

    always @(negedge clk) begin
        if (p_cs === 1'b1 && adc_cs_n === 1'b0) begin
            falls.push_back(cyc);
            rises = 0;
        end
        if (p_sclk === 1'b0 && adc_sclk === 1'b1 && adc_cs_n === 1'b0) rises++;
        if (p_cs === 1'b1 && adc_cs_n === 1'b1 && p_sclk !== adc_sclk) bad_sclk++;
        if (falls.size() > 0 && out_w !== p_out) out_cyc = cyc - falls[$];
        if (p_rdy === 1'b0 && rdy_w === 1'b1) begin
            if (falls.size() > 0) rdy_start = cyc - falls[$];
            got.push_back(out_w);
            rdy_cnt++;
        end
        if (p_rdy === 1'b1 && rdy_w === 1'b0 && falls.size() > 0)
            rdy_end = cyc - 1 - falls[$];
        p_cs   = adc_cs_n;
        p_sclk = adc_sclk;
        p_rdy  = rdy_w;
        p_out  = out_w;
    end

    task automatic wait_rdy(input int n, input int budget, input string tag);
        int k = 0;
        while (rdy_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(rdy_cnt >= n), 32'd1);
    endtask

    initial begin
        int f_last;
        int n0;
        int k;

        rst_n = 1'b0;
        en    = 1'b0;
        hold  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
        chk("rst_sclk", 32'(adc_sclk), 32'd1);
        chk("rst_out",  32'(out_w),    32'd0);
        chk("rst_rdy",  32'(rdy_w),    32'd0);
        rst_n = 1'b1;

        // Disabled: no frames for 3000 cycles
        repeat (3000) @(negedge clk);
        chk("en0_no_frame", 32'(falls.size()), 32'd0);

        // Single capture then pacing
        adc_q.push_back(12'hABC);
        adc_q.push_back(12'h001);
        adc_q.push_back(12'h800);
        adc_q.push_back(12'hFFF);
        en = 1'b1;
        wait_rdy(1, 1300, "cap1_timeout");
        repeat (4) @(negedge clk);
        chk("cap1_out",       32'(got[0]),  32'hABC);
        chk("cap1_out_cycle", 32'(out_cyc), 32'd129);
        chk("cap1_rdy_start", 32'(rdy_start), 32'd130);
        chk("cap1_rdy_end",   32'(rdy_end),   32'd131);
        chk("cap1_rises",     32'(rises),     32'd16);

        wait_rdy(4, 3200, "pace_timeout");
        chk("pace_gap1", 32'(falls[1] - falls[0]), 32'd1000);
        chk("pace_gap2", 32'(falls[2] - falls[1]), 32'd1000);
        chk("pace_gap3", 32'(falls[3] - falls[2]), 32'd1000);
        chk("pace_s1",   32'(got[1]), 32'h001);
        chk("pace_s2",   32'(got[2]), 32'h800);
        chk("pace_s3",   32'(got[3]), 32'hFFF);

        // Hold across one tick: that tick is dropped, the next captures
        f_last = falls[3];
        hold   = 1'b1;
        adc_q.push_back(12'h5A5);
        while (cyc < f_last + 1500) @(negedge clk);
        hold = 1'b0;
        wait_rdy(5, 800, "hold_timeout");
        chk("hold_frames", 32'(falls.size()), 32'd5);
        chk("hold_gap",    32'(falls[4] - f_last), 32'd2000);
        chk("hold_sample", 32'(got[4]), 32'h5A5);
`ifdef ADC_DROPCNT_EN
        chk("hold_dropcnt", 32'(drop_cnt_w), 32'd1);
`endif

        // Reset at frame cycle 60
        adc_q.push_back(12'h111);
        adc_q.push_back(12'h3C7);
        k = 0;
        while (adc_cs_n !== 1'b0 && k < 1200) begin
            @(negedge clk);
            k++;
        end
        chk("mid_frame_start", 32'(adc_cs_n), 32'd0);
        repeat (59) @(negedge clk);
        n0    = rdy_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_cs_n", 32'(adc_cs_n), 32'd1);
        chk("mid_rst_sclk", 32'(adc_sclk), 32'd1);
        chk("mid_rst_rdy",  32'(rdy_w),    32'd0);
        rst_n = 1'b1;
        wait_rdy(n0 + 1, 1300, "mid_rst_timeout");
        repeat (4) @(negedge clk);
        chk("mid_rst_rdy_count", 32'(rdy_cnt), 32'(n0 + 1));
        chk("mid_rst_sample",    32'(got[$]),  32'h3C7);
        chk("mid_rst_rises",     32'(rises),   32'd16);
        chk("sclk_idle_stable",  32'(bad_sclk), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
